// File: rtl/alu_sequencer.sv
// Four-phase execute/write-back controller in front of a 4-entry 2R/1W register file.
// Handles one instruction per 4 cycles: accept, read operands, execute, write back.
module alu_sequencer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [8:0]   instr,
   input  logic [W-1:0] imm,
   output logic [1:0]   rf_out1_sel,
   output logic [1:0]   rf_out2_sel,
   input  logic [W-1:0] rf_rd1,
   input  logic [W-1:0] rf_rd2,
   output logic         rf_en,
   output logic [1:0]   rf_in_sel,
   output logic [W-1:0] rf_in,
   output logic         done,
   output logic         flag_z,
   output logic         flag_c
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_MOV = 3'b110;

   state_t       state_q, state_d;
   logic [2:0]   op_q, op_d;
   logic [1:0]   dst_q, dst_d;
   logic [1:0]   sel1_q, sel1_d;
   logic [1:0]   sel2_q, sel2_d;
   logic [W-1:0] imm_q, imm_d;
   logic [W-1:0] opa_q, opa_d;
   logic [W-1:0] opb_q, opb_d;
   logic [W-1:0] result_q, result_d;
   logic         carry_q, carry_d;
   logic         rf_en_q, rf_en_d;
   logic         done_q, done_d;
   logic         flag_z_q, flag_z_d;
   logic         flag_c_q, flag_c_d;
   logic [W:0]   sum;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      dst_d    = dst_q;
      sel1_d   = sel1_q;
      sel2_d   = sel2_q;
      imm_d    = imm_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      carry_d  = carry_q;
      rf_en_d  = rf_en_q;
      done_d   = done_q;
      flag_z_d = flag_z_q;
      flag_c_d = flag_c_q;
      sum      = {1'b0, opa_q} + {1'b0, opb_q};

      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               op_d    = instr[8:6];
               dst_d   = instr[5:4];
               sel1_d  = instr[3:2];
               sel2_d  = instr[1:0];
               imm_d   = imm;
               state_d = S_READ;
            end
         end
         S_READ: begin
            opa_d   = rf_rd1;
            opb_d   = rf_rd2;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            carry_d = 1'b0;
            case (op_q)
               OP_NOP: result_d = '0;
               OP_ADD: begin
                  result_d = sum[W-1:0];
                  carry_d  = sum[W];
               end
               OP_SUB: begin
                  result_d = opa_q - opb_q;
                  carry_d  = (opa_q < opb_q);
               end
               OP_AND:  result_d = opa_q & opb_q;
               OP_OR:   result_d = opa_q | opb_q;
               OP_XOR:  result_d = opa_q ^ opb_q;
               OP_MOV:  result_d = opa_q;
               default: result_d = imm_q;
            endcase
            rf_en_d = (op_q != OP_NOP);
            done_d  = 1'b1;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            rf_en_d = 1'b0;
            done_d  = 1'b0;
            // Flags follow the retiring result; NOP keeps the previous ones.
            if (op_q != OP_NOP) begin
               flag_z_d = (result_q == '0);
               flag_c_d = carry_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         dst_q    <= '0;
         sel1_q   <= '0;
         sel2_q   <= '0;
         imm_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         rf_en_q  <= 1'b0;
         done_q   <= 1'b0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         dst_q    <= dst_d;
         sel1_q   <= sel1_d;
         sel2_q   <= sel2_d;
         imm_q    <= imm_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         rf_en_q  <= rf_en_d;
         done_q   <= done_d;
         flag_z_q <= flag_z_d;
         flag_c_q <= flag_c_d;
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign rf_out1_sel = sel1_q;
   assign rf_out2_sel = sel2_q;
   assign rf_en       = rf_en_q;
   assign rf_in_sel   = dst_q;
   assign rf_in       = result_q;
   assign done        = done_q;
   assign flag_z      = flag_z_q;
   assign flag_c      = flag_c_q;

endmodule
